// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Hazard detection and operand-forwarding control for the 5-stage RV32I pipe.
// A small tag pipeline (EX, MEM, WB) mirrors the register usage of the
// instructions in flight. It drives the EX operand-mux selects, the one-cycle
// load-use stall and the flush bubble.
// Optional build macro: HAZ_STATS_EN enables a saturating stall-cycle counter
// on stall_count. Without it, stall_count is tied to zero.
module hazard_fwd_unit #(
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [REG_AW-1:0]      id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   ex_valid,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } tag_t;

  // Operand-mux select encodings.
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  tag_t id_tag;
  tag_t ex_q, ex_d;
  tag_t mem_q, mem_d;
  tag_t wb_q, wb_d;

  assign id_tag = '{valid:    1'b1,
                    rs1:      id_rs1,
                    rs2:      id_rs2,
                    rs1_used: id_rs1_used,
                    rs2_used: id_rs2_used,
                    rd:       id_rd,
                    regwrite: id_regwrite,
                    memread:  id_memread};

  assign ex_valid = ex_q.valid;

  // Load-use detection: a load in EX whose rd is read by the instruction in ID.
  // A taken branch in EX kills ID, so flush suppresses the stall.
  always_comb begin
    stall = 1'b0;
    if (!flush && id_valid && ex_q.valid && ex_q.memread && ex_q.regwrite &&
        (ex_q.rd != '0)) begin
      stall = (id_rs1_used && (id_rs1 == ex_q.rd)) ||
              (id_rs2_used && (id_rs2 == ex_q.rd));
    end
  end

  // Next tag state: ID enters EX unless it is stalled, flushed or empty. The
  // older stages always advance, so a flushing branch still moves on to MEM.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so every path drives the signal and no latch is inferred.
    ex_d  = '0;
    mem_d = ex_q;
    wb_d  = mem_q;
    if (id_valid && !stall && !flush) begin
      ex_d = id_tag;
    end
  end

  // Tag pipeline registers. Reset drops every in-flight tag without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so all stages update
    // from the pre-edge values. The async reset clears each stage completely.
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // Forwarding selects. The MEM ALU result is the youngest value, so it has
  // priority. A load in MEM has no data yet and is never a source. x0 never
  // forwards.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (mem_q.valid && mem_q.regwrite && !mem_q.memread && (mem_q.rd != '0) &&
        ex_q.rs1_used && (mem_q.rd == ex_q.rs1)) begin
      fwd_a_sel = SEL_MEM;
    end else if (wb_q.valid && wb_q.regwrite && (wb_q.rd != '0) &&
                 ex_q.rs1_used && (wb_q.rd == ex_q.rs1)) begin
      fwd_a_sel = SEL_WB;
    end
    if (mem_q.valid && mem_q.regwrite && !mem_q.memread && (mem_q.rd != '0) &&
        ex_q.rs2_used && (mem_q.rd == ex_q.rs2)) begin
      fwd_b_sel = SEL_MEM;
    end else if (wb_q.valid && wb_q.regwrite && (wb_q.rd != '0) &&
                 ex_q.rs2_used && (wb_q.rd == ex_q.rs2)) begin
      fwd_b_sel = SEL_WB;
    end
  end

  // The WB entry only needs its destination fields. Its source fields are
  // carried for uniformity and are otherwise unused.
  logic unused_wb_bits;
  assign unused_wb_bits = ^{wb_q.rs1, wb_q.rs2, wb_q.rs1_used, wb_q.rs2_used,
                            wb_q.memread};

`ifdef HAZ_STATS_EN
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  // Saturating count of stall cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  // Stall counter register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule
